// File: rtl/punc_mem_defs.sv
// Shared state encoding and defaults for the PUnC memory access sequencer.
package punc_mem_defs;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
  } state_e;

  localparam int unsigned DefaultTimeout = 15;

  function automatic logic st_busy(state_e s);
    return s != StIdle;
  endfunction

  function automatic logic st_counting(state_e s);
    return (s == StReq) || (s == StWait);
  endfunction

endpackage

// File: rtl/punc_mem_timeout.sv
// Cycle counter for the REQ+WAIT phase; expire_o flags the last allowed cycle.
module punc_mem_timeout #(
  parameter int unsigned Timeout = punc_mem_defs::DefaultTimeout
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/punc_mem_seq.sv
// Sequencer turning level-held PUnC read/write strobes into a req/gnt/rvalid
// memory transaction, with registered read data, done pulse and timeout abort.
module punc_mem_seq
  import punc_mem_defs::*;
#(
  parameter int unsigned AddrW   = 16,
  parameter int unsigned DataW   = 16,
  parameter int unsigned Timeout = DefaultTimeout
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cpu_rd_i,
  input  logic             cpu_wr_i,
  input  logic [AddrW-1:0] cpu_addr_i,
  input  logic [DataW-1:0] cpu_wdata_i,
  output logic             cpu_done_o,
  output logic             cpu_err_o,
  output logic [DataW-1:0] cpu_rdata_o,
  output logic             busy_o,
  output logic             err_sticky_o,
  input  logic             err_clr_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [DataW-1:0] mem_rdata_i
);

  state_e           state_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [DataW-1:0] mem_wdata_q;
  logic             cpu_done_q;
  logic             cpu_err_q;
  logic [DataW-1:0] cpu_rdata_q;
  logic             illegal_q;
  logic             err_sticky_q;
  logic             expire;

  punc_mem_timeout #(
    .Timeout (Timeout)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q == StIdle),
    .en_i     (st_counting(state_q)),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      illegal_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      cpu_err_q  <= 1'b0;
      // Clear first so a same-cycle error set below takes priority.
      if (err_clr_i) begin
        err_sticky_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cpu_rd_i || cpu_wr_i) begin
            mem_addr_q  <= cpu_addr_i;
            mem_wdata_q <= cpu_wdata_i;
            mem_we_q    <= cpu_wr_i;
            illegal_q   <= cpu_rd_i && cpu_wr_i;
            mem_req_q   <= 1'b1;
            state_q     <= StReq;
          end
        end

        StReq: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              cpu_done_q <= 1'b1;
              cpu_err_q  <= illegal_q;
              state_q    <= StDone;
            end else begin
              state_q <= StWait;
            end
          end else if (expire) begin
            mem_req_q  <= 1'b0;
            cpu_done_q <= 1'b1;
            cpu_err_q  <= 1'b1;
            state_q    <= StErr;
          end
        end

        StWait: begin
          if (mem_rvalid_i) begin
            cpu_rdata_q <= mem_rdata_i;
            cpu_done_q  <= 1'b1;
            cpu_err_q   <= illegal_q;
            state_q     <= StDone;
          end else if (expire) begin
            cpu_done_q <= 1'b1;
            cpu_err_q  <= 1'b1;
            state_q    <= StErr;
          end
        end

        StDone: begin
          if (illegal_q) begin
            err_sticky_q <= 1'b1;
          end
          state_q <= StIdle;
        end

        StErr: begin
          err_sticky_q <= 1'b1;
          state_q      <= StIdle;
        end

        default: begin
          mem_req_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign busy_o       = st_busy(state_q);
  assign cpu_done_o   = cpu_done_q;
  assign cpu_err_o    = cpu_err_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign err_sticky_o = err_sticky_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_punc_mem_seq.sv
// Directed bench for punc_mem_seq: read/write latency, wait states, timeout,
// rvalid-at-timeout boundary, illegal strobes and mid-transaction reset.
module tb_punc_mem_seq;

  logic        clk;
  logic        rst_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_done;
  logic        cpu_err;
  logic [15:0] cpu_rdata;
  logic        busy;
  logic        err_sticky;
  logic        err_clr;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  punc_mem_seq #(
    .AddrW   (16),
    .DataW   (16),
    .Timeout (15)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_rd_i     (cpu_rd),
    .cpu_wr_i     (cpu_wr),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_done_o   (cpu_done),
    .cpu_err_o    (cpu_err),
    .cpu_rdata_o  (cpu_rdata),
    .busy_o       (busy),
    .err_sticky_o (err_sticky),
    .err_clr_i    (err_clr),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    cpu_rd     = 1'b0;
    cpu_wr     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    err_clr    = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_sticky", err_sticky, 0);
    rst_n = 1'b1;
    tick();

    // Zero-wait read: cycle 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
    cpu_rd   = 1'b1;
    cpu_addr = 16'h3000;
    tick();
    chk("rd_c1_req", mem_req, 1);
    chk("rd_c1_we", mem_we, 0);
    chk("rd_c1_addr", mem_addr, 16'h3000);
    chk("rd_c1_busy", busy, 1);
    mem_gnt = 1'b1;
    tick();
    chk("rd_c2_req", mem_req, 0);
    chk("rd_c2_done", cpu_done, 0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    tick();
    chk("rd_c3_done", cpu_done, 1);
    chk("rd_c3_err", cpu_err, 0);
    chk("rd_c3_rdata", cpu_rdata, 16'hBEEF);
    chk("rd_c3_req", mem_req, 0);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    cpu_rd     = 1'b0;
    tick();
    chk("rd_c4_done", cpu_done, 0);
    chk("rd_c4_busy", busy, 0);

    // Write with 3 wait states: REQ cycles 1..4, DONE at cycle 5
    cpu_wr    = 1'b1;
    cpu_addr  = 16'h3001;
    cpu_wdata = 16'h1234;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("wr_req", mem_req, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 16'h3001);
      chk("wr_wdata", mem_wdata, 16'h1234);
      chk("wr_nodone", cpu_done, 0);
      cpu_addr  = 16'hDEAD;
      cpu_wdata = 16'hFFFF;
      if (i == 4) mem_gnt = 1'b1;
      tick();
    end
    chk("wr_c5_done", cpu_done, 1);
    chk("wr_c5_err", cpu_err, 0);
    chk("wr_c5_we", mem_we, 1);
    chk("wr_c5_req", mem_req, 0);
    mem_gnt = 1'b0;
    cpu_wr  = 1'b0;
    tick();
    chk("wr_c6_busy", busy, 0);

    // Read timeout: 15 REQ cycles without gnt, ERR at cycle 16
    cpu_rd   = 1'b1;
    cpu_addr = 16'h3002;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("to_req", mem_req, 1);
      chk("to_nodone", cpu_done, 0);
      tick();
    end
    chk("to_done", cpu_done, 1);
    chk("to_err", cpu_err, 1);
    chk("to_rdata_hold", cpu_rdata, 16'hBEEF);
    chk("to_req_drop", mem_req, 0);
    cpu_rd = 1'b0;
    tick();
    chk("to_sticky", err_sticky, 1);
    chk("to_idle_done", cpu_done, 0);
    chk("to_idle_busy", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_sticky_clr", err_sticky, 0);

    // rvalid in the exact timeout cycle (counter 14 at cycle 15) wins
    cpu_rd   = 1'b1;
    cpu_addr = 16'h3003;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 2; i <= 14; i++) begin
      chk("bd_wait_req", mem_req, 0);
      chk("bd_wait_nodone", cpu_done, 0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hCAFE;
    tick();
    chk("bd_done", cpu_done, 1);
    chk("bd_err", cpu_err, 0);
    chk("bd_rdata", cpu_rdata, 16'hCAFE);
    mem_rvalid = 1'b0;
    cpu_rd     = 1'b0;
    tick();
    chk("bd_sticky", err_sticky, 0);

    // Illegal strobes: write issued, completion flagged as error
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = 16'h3004;
    cpu_wdata = 16'h5555;
    tick();
    chk("il_req", mem_req, 1);
    chk("il_we", mem_we, 1);
    chk("il_wdata", mem_wdata, 16'h5555);
    mem_gnt = 1'b1;
    tick();
    chk("il_done", cpu_done, 1);
    chk("il_err", cpu_err, 1);
    chk("il_rdata_hold", cpu_rdata, 16'hCAFE);
    mem_gnt = 1'b0;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    tick();
    chk("il_sticky", err_sticky, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("il_sticky_clr", err_sticky, 0);

    // Async reset while in WAIT
    cpu_rd   = 1'b1;
    cpu_addr = 16'h3005;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("ar_wait_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_req", mem_req, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_rdata", cpu_rdata, 0);
    cpu_rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ar_nodone", cpu_done, 0);
    end
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_post_nodone", cpu_done, 0);
    chk("ar_post_busy", busy, 0);

    // Read after reset completes normally
    cpu_rd   = 1'b1;
    cpu_addr = 16'h3006;
    tick();
    chk("pr_req", mem_req, 1);
    chk("pr_addr", mem_addr, 16'h3006);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h0A0A;
    tick();
    chk("pr_done", cpu_done, 1);
    chk("pr_err", cpu_err, 0);
    chk("pr_rdata", cpu_rdata, 16'h0A0A);
    mem_rvalid = 1'b0;
    cpu_rd     = 1'b0;
    tick();
    chk("pr_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/punc_mem_seq.md
Name: punc_mem_seq

Overview:
- Memory access sequencer between the PUnC control/datapath and a variable-latency memory port.
- Converts the level-held read/write strobes from the control unit into a req/gnt/rvalid transaction on the memory side.
- Registers read data for the register file.
- Returns a one-cycle done pulse; the control FSM holds its execute state until that pulse arrives.
- A timeout aborts stuck transactions and reports an error.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 15, max cycles spent in REQ+WAIT before abort (must be >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_rd  in  1  read request, held high until cpu_done
- cpu_wr  in  1  write request, held high until cpu_done
- cpu_addr  in  ADDR_W  transaction address
- cpu_wdata  in  DATA_W  write data
- cpu_done  out  1  one-cycle completion pulse (success or abort)
- cpu_err  out  1  qualifies cpu_done: transaction aborted or illegal
- cpu_rdata  out  DATA_W  last successfully read word (registered)
- busy  out  1  high in any state other than IDLE
- err_sticky  out  1  set on any error; cleared by err_clr
- err_clr  in  1  synchronous clear of err_sticky
- mem_req  out  1  request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (rst low, async):
  - state=IDLE; all outputs 0.
  - cpu_rdata=0, err_sticky=0, timeout counter=0.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - If cpu_rd|cpu_wr: latch cpu_addr, cpu_wdata and we=cpu_wr into mem_addr/mem_wdata/mem_we; clear counter; go to REQ.
  - cpu_rd and cpu_wr both high: the write is performed and an illegal flag is latched; completion then reports cpu_err=1 and sets err_sticky.
- REQ:
  - mem_req=1, with address, data and we stable.
  - mem_gnt=1 with we=1: go to DONE (write completes on grant).
  - mem_gnt=1 with we=0: go to WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: cpu_rdata<=mem_rdata; go to DONE.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT-1 and no gnt/rvalid arrives that cycle, go to ERR. An abort therefore completes after TIMEOUT cycles in REQ+WAIT.
  - gnt/rvalid arriving in that same cycle takes priority over the timeout.
- DONE:
  - cpu_done=1 for one cycle; cpu_err=illegal flag; go to IDLE.
- ERR:
  - cpu_done=1, cpu_err=1, err_sticky<=1; go to IDLE.
  - cpu_rdata is unchanged.
- Requests are not sampled in DONE/ERR. The controller drops its strobe on the edge that consumes cpu_done, so no request is re-accepted.
- err_clr and a new error in the same cycle: set wins.
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid in first WAIT cycle):
  - Read: request seen in IDLE at cycle 0 → cpu_done at cycle 3.
  - Write: cpu_done at cycle 2.
- Changes to cpu_addr/cpu_wdata after acceptance are ignored.
- busy=1 in REQ, WAIT, DONE and ERR.
- Reset asserted mid-transaction: immediate return to IDLE; mem_req drops asynchronously; no cpu_done is issued.

Decomposition:
- Shared defines package punc_mem_defs:
  - state encodings (3-bit): IDLE=0, REQ=1, WAIT=2, DONE=3, ERR=4
  - default TIMEOUT
- One sub-module, punc_mem_timeout:
  - counter, width $clog2(TIMEOUT); clear input, enable input, expire output.
  - Same clk/rst convention as the parent.

Test Plan:
- Zero-wait read: cpu_rd=1, addr=16'h3000, gnt in first REQ cycle, rvalid with rdata=16'hBEEF in first WAIT cycle → cpu_done at cycle 3 with cpu_err=0; cpu_rdata=16'hBEEF; mem_req high exactly 1 cycle.
- Write with 3 wait states: cpu_wr=1, addr=16'h3001, wdata=16'h1234, gnt delayed 3 cycles → mem_addr/mem_wdata stable for all 4 REQ cycles; cpu_done at cycle 5; mem_we=1 throughout.
- Read timeout, TIMEOUT=15: gnt never asserted → cpu_done with cpu_err=1 after 15 cycles in REQ; err_sticky=1; cpu_rdata holds its prior value. Pulse err_clr → err_sticky=0.
- Boundary: rvalid arrives in the exact timeout cycle → normal DONE, cpu_err=0, data captured.
- Illegal strobes: cpu_rd=cpu_wr=1 → write issued (mem_we=1); cpu_done with cpu_err=1; err_sticky=1.
- Async reset: assert rst low while in WAIT → state IDLE and mem_req=0 immediately, no done pulse; the next read after release completes normally.
